// File: rtl/dmem_pipe.sv
// dmem_pipe: pipelined byte-addressed data memory with valid/ready request and
// response handshakes, configurable read latency and per-access fault reporting.
// Faulting accesses never modify storage; storage itself is not reset.
module dmem_pipe #(
  parameter logic [31:0] BASE_ADDR    = 32'h0100_0000,
  parameter int          DEPTH_BYTES  = 65536,
  parameter int          READ_LATENCY = 2,
  parameter int          FCNT_W       = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_we,
  output logic [2:0]        rsp_fault,
  output logic [FCNT_W-1:0] fault_count
);

  localparam int          AW       = $clog2(DEPTH_BYTES);
  localparam logic [32:0] END_ADDR = {1'b0, BASE_ADDR} + 33'(DEPTH_BYTES);

  logic [7:0]    mem [DEPTH_BYTES];

  logic          stall;
  logic          accept;
  logic [2:0]    nbytes;
  logic [32:0]   addr_lo;
  logic [32:0]   addr_hi;
  logic          range_err;
  logic          align_err;
  logic          size_err;
  logic [2:0]    fault;
  logic [AW-1:0] idx;
  logic [31:0]   rd_word;
  logic [31:0]   load_data;
  logic [31:0]   new_rdata;

  logic          pipe_valid [READ_LATENCY];
  logic [31:0]   pipe_rdata [READ_LATENCY];
  logic          pipe_we    [READ_LATENCY];
  logic [2:0]    pipe_fault [READ_LATENCY];

  // A presented but unconsumed response freezes the whole pipe.
  assign stall     = rsp_valid && !rsp_ready;
  assign req_ready = !reset && !stall;
  assign accept    = req_valid && req_ready;

  // Decode access size, evaluate fault bits and assemble extended load data from storage.
  always_comb begin
    nbytes    = 3'd4;
    size_err  = 1'b0;
    align_err = 1'b0;
    range_err = 1'b0;
    load_data = '0;
    rd_word   = '0;
    case (req_size)
      2'b00:   nbytes = 3'd1;
      2'b01:   nbytes = 3'd2;
      2'b10:   nbytes = 3'd4;
      default: begin
        nbytes   = 3'd4;
        size_err = 1'b1;
      end
    endcase
    addr_lo = {1'b0, req_addr};
    addr_hi = addr_lo + {30'd0, nbytes} - 33'd1;
    if (!size_err) begin
      range_err = (addr_lo < {1'b0, BASE_ADDR}) || (addr_hi >= END_ADDR);
      align_err = (req_size == 2'b01 && req_addr[0]) ||
                  (req_size == 2'b10 && req_addr[1:0] != 2'b00);
    end
    fault = {size_err, align_err, range_err};
    idx   = AW'(req_addr - BASE_ADDR);
    for (int k = 0; k < 4; k++) begin
      rd_word[8*k +: 8] = mem[idx + AW'(k)];
    end
    case (req_size)
      2'b00:   load_data = {{24{req_signed & rd_word[7]}}, rd_word[7:0]};
      2'b01:   load_data = {{16{req_signed & rd_word[15]}}, rd_word[15:0]};
      2'b10:   load_data = rd_word;
      default: load_data = '0;
    endcase
    new_rdata = (req_we || fault != 3'b000) ? '0 : load_data;
  end

  // Response pipeline: stage 0 captures the accepted request, all stages shift together unless stalled.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < READ_LATENCY; i++) begin
        pipe_valid[i] <= 1'b0;
        pipe_rdata[i] <= '0;
        pipe_we[i]    <= 1'b0;
        pipe_fault[i] <= '0;
      end
    end else if (!stall) begin
      pipe_valid[0] <= accept;
      pipe_rdata[0] <= accept ? new_rdata : '0;
      pipe_we[0]    <= accept & req_we;
      pipe_fault[0] <= accept ? fault : '0;
      for (int i = 1; i < READ_LATENCY; i++) begin
        pipe_valid[i] <= pipe_valid[i-1];
        pipe_rdata[i] <= pipe_rdata[i-1];
        pipe_we[i]    <= pipe_we[i-1];
        pipe_fault[i] <= pipe_fault[i-1];
      end
    end
  end

  assign rsp_valid = pipe_valid[READ_LATENCY-1];
  assign rsp_rdata = pipe_rdata[READ_LATENCY-1];
  assign rsp_we    = pipe_we[READ_LATENCY-1];
  assign rsp_fault = pipe_fault[READ_LATENCY-1];

  // Saturating count of accepted requests that carried any fault.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      fault_count <= '0;
    end else if (accept && fault != 3'b000 && fault_count != '1) begin
      fault_count <= fault_count + FCNT_W'(1);
    end
  end

  // Commit fault-free stores at the acceptance edge; storage has no reset.
  always_ff @(posedge clock) begin
    if (accept && req_we && fault == 3'b000) begin
      for (int k = 0; k < 4; k++) begin
        if (3'(k) < nbytes) begin
          mem[idx + AW'(k)] <= req_wdata[8*k +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_dmem_pipe.sv
// tb_dmem_pipe: directed scoreboard bench for dmem_pipe. Stimulus pushes the
// hand-computed response into a queue; an independent monitor pops and compares
// whenever a response handshake occurs.
module tb_dmem_pipe;

  localparam int LAT = 2;
  localparam int FW  = 4;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [31:0]   req_addr = '0;
  logic [31:0]   req_wdata = '0;
  logic          req_we = 1'b0;
  logic [1:0]    req_size = 2'b00;
  logic          req_signed = 1'b0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b1;
  logic [31:0]   rsp_rdata;
  logic          rsp_we;
  logic [2:0]    rsp_fault;
  logic [FW-1:0] fault_count;

  typedef struct {
    logic [31:0] rdata;
    logic        we;
    logic [2:0]  fault;
    int          acc;
    bit          lat;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;

  // Free-running clock and cycle counter used for latency checks.
  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  dmem_pipe #(
    .BASE_ADDR   (32'h0100_0000),
    .DEPTH_BYTES (65536),
    .READ_LATENCY(LAT),
    .FCNT_W      (FW)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_we     (req_we),
    .req_size   (req_size),
    .req_signed (req_signed),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_rdata  (rsp_rdata),
    .rsp_we     (rsp_we),
    .rsp_fault  (rsp_fault),
    .fault_count(fault_count)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // Issue one request (called just after a rising edge), wait for acceptance and record the expected response.
  task automatic applyStimulus(input logic [31:0] addr, input logic [31:0] wdata, input logic we,
                               input logic [1:0] size, input logic sgn,
                               input logic [31:0] exp_rdata, input logic [2:0] exp_fault,
                               input bit chk_lat);
    exp_t e;
    int   waited;
    req_valid  = 1'b1;
    req_addr   = addr;
    req_wdata  = wdata;
    req_we     = we;
    req_size   = size;
    req_signed = sgn;
    waited     = 0;
    do begin
      @(negedge clock);
      waited++;
    end while (!req_ready && waited < 50);
    if (!req_ready) begin
      n_checks++;
      n_fail++;
      $display("[TB] FAIL req_timeout: got req_ready=0 for addr %h, expected acceptance", addr);
    end else begin
      e.rdata = exp_rdata;
      e.we    = we;
      e.fault = exp_fault;
      e.acc   = cyc + 1;
      e.lat   = chk_lat;
      exp_q.push_back(e);
    end
    @(posedge clock);
    #1;
    req_valid = 1'b0;
  endtask

  // Wait for the scoreboard to empty, bounded.
  task automatic waitDrain();
    int w;
    w = 0;
    while (exp_q.size() != 0 && w < 100) begin
      @(negedge clock);
      w++;
    end
    if (exp_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("[TB] FAIL drain_timeout: got %0d pending responses, expected 0", exp_q.size());
    end
    @(posedge clock);
    #1;
  endtask

  // Monitor: compare each consumed response against the head of the scoreboard.
  always @(negedge clock) begin
    if (!reset && rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("[TB] FAIL unexpected_rsp: got rdata %h fault %b, expected no response", rsp_rdata, rsp_fault);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        checkOutput("rsp_rdata", rsp_rdata, e.rdata);
        checkOutput("rsp_we", {31'd0, rsp_we}, {31'd0, e.we});
        checkOutput("rsp_fault", {29'd0, rsp_fault}, {29'd0, e.fault});
        if (e.lat) checkOutput("rsp_latency", cyc - e.acc, LAT - 1);
      end
    end
  end

  // Watchdog so the run always terminates.
  initial begin
    #300000;
    $display("[TB] FAIL watchdog: got timeout, expected end of test");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed test sequence.
  initial begin
    // Power-on reset
    repeat (2) @(posedge clock);
    @(negedge clock);
    checkOutput("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    checkOutput("reset_req_ready", {31'd0, req_ready}, 32'd0);
    checkOutput("reset_fault_count", 32'(fault_count), 32'd0);
    @(posedge clock);
    #1;
    reset = 1'b0;

    // Test 1: reset mid-burst of reads
    applyStimulus(32'h0100_0020, 32'h1234_5678, 1'b1, 2'b10, 1'b0, 32'h0, 3'b000, 1'b0);
    applyStimulus(32'h0100_0020, 32'h0, 1'b0, 2'b10, 1'b0, 32'h1234_5678, 3'b000, 1'b0);
    applyStimulus(32'h0100_0020, 32'h0, 1'b0, 2'b10, 1'b0, 32'h1234_5678, 3'b000, 1'b0);
    applyStimulus(32'h0100_0020, 32'h0, 1'b0, 2'b10, 1'b0, 32'h1234_5678, 3'b000, 1'b0);
    reset = 1'b1;
    exp_q.delete();
    repeat (3) begin
      @(negedge clock);
      checkOutput("midreset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      checkOutput("midreset_req_ready", {31'd0, req_ready}, 32'd0);
      checkOutput("midreset_rsp_rdata", rsp_rdata, 32'd0);
    end
    checkOutput("midreset_fault_count", 32'(fault_count), 32'd0);
    @(posedge clock);
    #1;
    reset = 1'b0;
    repeat (3) begin
      @(negedge clock);
      checkOutput("postreset_idle_valid", {31'd0, rsp_valid}, 32'd0);
    end
    @(posedge clock);
    #1;
    applyStimulus(32'h0100_0020, 32'h0, 1'b0, 2'b10, 1'b0, 32'h1234_5678, 3'b000, 1'b0);
    waitDrain();

    // Test 2: word store then sign/zero-extended sub-word loads
    applyStimulus(32'h0100_0010, 32'hDEAD_BEEF, 1'b1, 2'b10, 1'b0, 32'h0, 3'b000, 1'b0);
    applyStimulus(32'h0100_0013, 32'h0, 1'b0, 2'b00, 1'b1, 32'hFFFF_FFDE, 3'b000, 1'b0);
    applyStimulus(32'h0100_0013, 32'h0, 1'b0, 2'b00, 1'b0, 32'h0000_00DE, 3'b000, 1'b0);
    applyStimulus(32'h0100_0010, 32'h0, 1'b0, 2'b01, 1'b1, 32'hFFFF_BEEF, 3'b000, 1'b0);
    applyStimulus(32'h0100_0012, 32'h0, 1'b0, 2'b01, 1'b0, 32'h0000_DEAD, 3'b000, 1'b0);
    applyStimulus(32'h0100_0010, 32'h0, 1'b0, 2'b00, 1'b1, 32'hFFFF_FFEF, 3'b000, 1'b0);
    applyStimulus(32'h0100_0010, 32'h0, 1'b0, 2'b10, 1'b1, 32'hDEAD_BEEF, 3'b000, 1'b0);
    waitDrain();

    // Test 3: back-to-back store then loads, exact latency
    applyStimulus(32'h0100_0000, 32'h0000_0011, 1'b1, 2'b00, 1'b0, 32'h0, 3'b000, 1'b1);
    applyStimulus(32'h0100_0000, 32'h0, 1'b0, 2'b00, 1'b0, 32'h0000_0011, 3'b000, 1'b1);
    applyStimulus(32'h0100_0011, 32'h0, 1'b0, 2'b00, 1'b1, 32'hFFFF_FFBE, 3'b000, 1'b1);
    applyStimulus(32'h0100_0010, 32'h0, 1'b0, 2'b10, 1'b0, 32'hDEAD_BEEF, 3'b000, 1'b1);
    waitDrain();

    // Test 4: response backpressure with three reads queued
    applyStimulus(32'h0100_0030, 32'h0000_00A1, 1'b1, 2'b00, 1'b0, 32'h0, 3'b000, 1'b0);
    applyStimulus(32'h0100_0031, 32'h0000_00B2, 1'b1, 2'b00, 1'b0, 32'h0, 3'b000, 1'b0);
    applyStimulus(32'h0100_0032, 32'h0000_00C3, 1'b1, 2'b00, 1'b0, 32'h0, 3'b000, 1'b0);
    waitDrain();
    rsp_ready = 1'b0;
    fork
      begin
        applyStimulus(32'h0100_0030, 32'h0, 1'b0, 2'b00, 1'b0, 32'h0000_00A1, 3'b000, 1'b0);
        applyStimulus(32'h0100_0031, 32'h0, 1'b0, 2'b00, 1'b0, 32'h0000_00B2, 3'b000, 1'b0);
        applyStimulus(32'h0100_0032, 32'h0, 1'b0, 2'b00, 1'b0, 32'h0000_00C3, 3'b000, 1'b0);
      end
      begin
        repeat (2) @(negedge clock);
        repeat (5) begin
          @(negedge clock);
          checkOutput("stall_req_ready", {31'd0, req_ready}, 32'd0);
          checkOutput("stall_rsp_valid", {31'd0, rsp_valid}, 32'd1);
          checkOutput("stall_rsp_rdata", rsp_rdata, 32'h0000_00A1);
        end
        @(posedge clock);
        #1;
        rsp_ready = 1'b1;
      end
    join
    waitDrain();
    @(negedge clock);
    checkOutput("no_dup_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    @(posedge clock);
    #1;

    // Test 5: fault reporting, faulting stores leave storage intact
    applyStimulus(32'h0100_0000, 32'h0102_0304, 1'b1, 2'b10, 1'b0, 32'h0, 3'b000, 1'b0);
    applyStimulus(32'h0100_0002, 32'hCAFE_F00D, 1'b1, 2'b10, 1'b0, 32'h0, 3'b010, 1'b0);
    applyStimulus(32'h0100_0000, 32'h0, 1'b0, 2'b10, 1'b0, 32'h0102_0304, 3'b000, 1'b0);
    applyStimulus(32'h00FF_FFFC, 32'h0, 1'b0, 2'b10, 1'b0, 32'h0, 3'b001, 1'b0);
    applyStimulus(32'h0101_FFFE, 32'h0, 1'b0, 2'b10, 1'b0, 32'h0, 3'b011, 1'b0);
    applyStimulus(32'h0100_0000, 32'hFFFF_FFFF, 1'b1, 2'b11, 1'b0, 32'h0, 3'b100, 1'b0);
    applyStimulus(32'h0100_0000, 32'h0, 1'b0, 2'b10, 1'b0, 32'h0102_0304, 3'b000, 1'b0);
    waitDrain();
    checkOutput("fault_count_4", 32'(fault_count), 32'd4);

    // Test 6: fault counter saturation
    for (int i = 0; i < 11; i++) begin
      applyStimulus(32'h0000_0000, 32'h0, 1'b0, 2'b10, 1'b0, 32'h0, 3'b001, 1'b0);
    end
    waitDrain();
    checkOutput("fault_count_max", 32'(fault_count), 32'd15);
    applyStimulus(32'h0100_0000, 32'h0, 1'b1, 2'b11, 1'b0, 32'h0, 3'b100, 1'b0);
    applyStimulus(32'h0100_0001, 32'h0, 1'b0, 2'b01, 1'b1, 32'h0, 3'b010, 1'b0);
    waitDrain();
    checkOutput("fault_count_sat", 32'(fault_count), 32'd15);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
